// File: rtl/lc3b_types.sv
// Shared types for the L2 port arbiter: grant FSM states, line type and grant encoding.
package lc3b_types;

  localparam int unsigned LC3B_LINE_WIDTH = 128;

  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } l2arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } l2arb_grant_t;

endpackage

// File: rtl/l2_arb_select.sv
// Combinational winner pick between instruction and data requests.
// L2ARB_ROUND_ROBIN_EN: ties go to the side not granted last; otherwise data always wins ties.
module l2_arb_select (
  input  logic i_req,
  input  logic d_req,
`ifdef L2ARB_ROUND_ROBIN_EN
  input  logic last_grant_d,
`endif
  output logic grant_d
);

  always_comb begin
    grant_d = 1'b0;
    if (d_req && !i_req) begin
      grant_d = 1'b1;
    end else if (d_req && i_req) begin
`ifdef L2ARB_ROUND_ROBIN_EN
      grant_d = !last_grant_d;
`else
      grant_d = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between the I-cache miss path and the D-side writeback path.
// Optional L2ARB_ROUND_ROBIN_EN enables tie-breaking on the last grant.
module l2_port_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic                  arb_busy
);

  l2arb_state_t state_q;
  logic         i_req;
  logic         d_req;
  logic         grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef L2ARB_ROUND_ROBIN_EN
  l2arb_grant_t last_grant_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_I;
    end else if (state_q == IDLE && (i_req || d_req)) begin
      last_grant_q <= grant_d ? GRANT_D : GRANT_I;
    end
  end

  l2_arb_select u_select (
    .i_req        (i_req),
    .d_req        (d_req),
    .last_grant_d (last_grant_q == GRANT_D),
    .grant_d      (grant_d)
  );
`else
  l2_arb_select u_select (
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_d (grant_d)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            if (grant_d) begin
              // A simultaneous read+write is illegal; the write takes precedence.
              state_q    <= D_BUSY;
              l2_read    <= d_read & ~d_write;
              l2_write   <= d_write;
              l2_address <= d_address;
              l2_wdata   <= d_wdata;
            end else begin
              state_q    <= I_BUSY;
              l2_read    <= 1'b1;
              l2_write   <= 1'b0;
              l2_address <= i_address;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (l2_resp) begin
            state_q  <= IDLE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_busy = (state_q != IDLE);
  assign i_resp   = (state_q == I_BUSY) && l2_resp;
  assign d_resp   = (state_q == D_BUSY) && l2_resp;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;

endmodule
